// File: rtl/regfile_writeback_pkg.sv
// Shared constants and types for the register-file writeback stage.
// Holds the register-index width, the default datapath width and the x0 index.
package regfile_writeback_pkg;

    localparam int REG_IDX_W    = 5;
    localparam int NUM_REGS     = 1 << REG_IDX_W;
    localparam int XLEN_DEFAULT = 32;
    localparam logic [REG_IDX_W-1:0] X0_IDX = '0;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_LOAD
    } main_src_e;

    function automatic logic is_x0(input logic [REG_IDX_W-1:0] idx);
        return idx == X0_IDX;
    endfunction

endpackage

// File: rtl/regfile_writeback_result_fifo.sv
// In-order buffer for load results waiting for the main register-file write port.
// Carries destination index and data; push is ignored when full, pop when empty.
module wb_result_fifo
    import regfile_writeback_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = XLEN_DEFAULT,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [REG_IDX_W-1:0] push_rd,
    input  logic [XLEN-1:0]      push_data,
    input  logic                 pop,
    output logic [REG_IDX_W-1:0] head_rd,
    output logic [XLEN-1:0]      head_data,
    output logic [CNT_W-1:0]     count,
    output logic                 full,
    output logic                 empty
);

    logic [REG_IDX_W-1:0] r_mem_rd   [DEPTH];
    logic [XLEN-1:0]      r_mem_data [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head_rd   = r_mem_rd[r_rd_ptr];
    assign head_data = r_mem_data[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem_rd[r_wr_ptr]   <= push_rd;
            r_mem_data[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback arbiter: ALU results take the main port, buffered loads fill idle slots,
// atomics use a second port and yield one cycle to a same-register main write.
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int MEM_FIFO_DEPTH = 2,
    parameter int XLEN           = XLEN_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic [REG_IDX_W-1:0] issue_rd,
    input  logic                 alu_valid,
    input  logic [REG_IDX_W-1:0] alu_rd,
    input  logic [XLEN-1:0]      alu_data,
    input  logic                 mem_valid,
    input  logic [REG_IDX_W-1:0] mem_rd,
    input  logic [XLEN-1:0]      mem_data,
    output logic                 mem_ready,
    input  logic                 amo_valid,
    input  logic [REG_IDX_W-1:0] amo_rd,
    input  logic [XLEN-1:0]      amo_data,
    output logic                 amo_ready,
    output logic [REG_IDX_W-1:0] rd,
    output logic                 write_enable,
    output logic [XLEN-1:0]      write_data,
    output logic [REG_IDX_W-1:0] atomic_rd,
    output logic                 atomic_write_enable,
    output logic [XLEN-1:0]      atomic_write_data,
    output logic [NUM_REGS-1:0]  busy
);

    localparam int CNT_W = $clog2(MEM_FIFO_DEPTH + 1);

    logic [REG_IDX_W-1:0] w_head_rd;
    logic [XLEN-1:0]      w_head_data;
    logic [CNT_W-1:0]     w_fifo_count;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_push;
    logic                 w_pop;

    main_src_e            w_src;
    logic                 w_main_valid;
    logic [REG_IDX_W-1:0] w_main_rd;
    logic [XLEN-1:0]      w_main_data;

    logic                 r_amo_valid;
    logic [REG_IDX_W-1:0] r_amo_rd;
    logic [XLEN-1:0]      r_amo_data;
    logic                 w_amo_accept;
    logic                 w_cand_valid;
    logic [REG_IDX_W-1:0] w_cand_rd;
    logic [XLEN-1:0]      w_cand_data;
    logic                 w_amo_conflict;
    logic                 w_amo_fire;

    logic [NUM_REGS-1:0]  r_busy;
    logic [NUM_REGS-1:0]  w_set_mask;
    logic [NUM_REGS-1:0]  w_clr_mask;
    logic [NUM_REGS-1:0]  w_busy_next;

    logic                 r_we;
    logic [REG_IDX_W-1:0] r_rd;
    logic [XLEN-1:0]      r_wd;
    logic                 r_awe;
    logic [REG_IDX_W-1:0] r_ard;
    logic [XLEN-1:0]      r_awd;

    wb_result_fifo #(
        .DEPTH (MEM_FIFO_DEPTH),
        .XLEN  (XLEN)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_rd   (mem_rd),
        .push_data (mem_data),
        .pop       (w_pop),
        .head_rd   (w_head_rd),
        .head_data (w_head_data),
        .count     (w_fifo_count),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    // Ready depends only on occupancy, never on this cycle's pop.
    assign mem_ready    = (w_fifo_count < CNT_W'(MEM_FIFO_DEPTH));
    assign amo_ready    = !r_amo_valid;
    assign w_push       = mem_valid && !w_fifo_full && !reset;
    assign w_amo_accept = amo_valid && !r_amo_valid && !reset;

    always_comb begin
        w_src       = SRC_NONE;
        w_main_rd   = X0_IDX;
        w_main_data = '0;
        if (alu_valid) begin
            w_src       = SRC_ALU;
            w_main_rd   = alu_rd;
            w_main_data = alu_data;
        end else if (!w_fifo_empty) begin
            w_src       = SRC_LOAD;
            w_main_rd   = w_head_rd;
            w_main_data = w_head_data;
        end
    end

    assign w_main_valid = (w_src != SRC_NONE) && !reset;
    assign w_pop        = (w_src == SRC_LOAD) && !reset;

    // A held AMO re-competes each cycle; a fresh one is considered in its accept cycle.
    assign w_cand_valid   = r_amo_valid || w_amo_accept;
    assign w_cand_rd      = r_amo_valid ? r_amo_rd   : amo_rd;
    assign w_cand_data    = r_amo_valid ? r_amo_data : amo_data;
    assign w_amo_conflict = w_cand_valid && w_main_valid &&
                            (w_cand_rd == w_main_rd) && !is_x0(w_cand_rd);
    assign w_amo_fire     = w_cand_valid && !w_amo_conflict;

    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (issue_valid)  w_set_mask[issue_rd]  = 1'b1;
        if (w_main_valid) w_clr_mask[w_main_rd] = 1'b1;
        if (w_amo_fire)   w_clr_mask[w_cand_rd] = 1'b1;
    end

    assign w_busy_next = ((r_busy & ~w_clr_mask) | w_set_mask) & ~NUM_REGS'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_amo_valid <= 1'b0;
            r_busy      <= '0;
            r_we        <= 1'b0;
            r_rd        <= X0_IDX;
            r_wd        <= '0;
            r_awe       <= 1'b0;
            r_ard       <= X0_IDX;
            r_awd       <= '0;
        end else begin
            r_amo_valid <= w_cand_valid && w_amo_conflict;
            r_busy      <= w_busy_next;
            r_we        <= w_main_valid && !is_x0(w_main_rd);
            r_awe       <= w_amo_fire && !is_x0(w_cand_rd);
            if (w_main_valid) begin
                r_rd <= w_main_rd;
                r_wd <= w_main_data;
            end
            if (w_amo_fire) begin
                r_ard <= w_cand_rd;
                r_awd <= w_cand_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_cand_valid && w_amo_conflict) begin
            r_amo_rd   <= w_cand_rd;
            r_amo_data <= w_cand_data;
        end
    end

    assign write_enable        = r_we;
    assign rd                  = r_rd;
    assign write_data          = r_wd;
    assign atomic_write_enable = r_awe;
    assign atomic_rd           = r_ard;
    assign atomic_write_data   = r_awd;
    assign busy                = r_busy;

endmodule

// File: tb/tb_regfile_writeback.sv
// Randomized and directed bench for regfile_writeback against a queue-based
// model of the writeback rules.
module tb_regfile_writeback;

    localparam int DEPTH = 2;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            issue_valid = 1'b0, alu_valid = 1'b0, mem_valid = 1'b0, amo_valid = 1'b0;
    logic [4:0]      issue_rd = '0, alu_rd = '0, mem_rd = '0, amo_rd = '0;
    logic [XLEN-1:0] alu_data = '0, mem_data = '0, amo_data = '0;
    logic            mem_ready, amo_ready, write_enable, atomic_write_enable;
    logic [4:0]      rd, atomic_rd;
    logic [XLEN-1:0] write_data, atomic_write_data;
    logic [31:0]     busy;

    regfile_writeback #(.MEM_FIFO_DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .amo_valid(amo_valid), .amo_rd(amo_rd), .amo_data(amo_data), .amo_ready(amo_ready),
        .rd(rd), .write_enable(write_enable), .write_data(write_data),
        .atomic_rd(atomic_rd), .atomic_write_enable(atomic_write_enable),
        .atomic_write_data(atomic_write_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Stimulus for the next cycle.
    logic            s_rst, s_iv, s_av, s_mv, s_amv;
    logic [4:0]      s_ird, s_ard, s_mrd, s_amrd;
    logic [XLEN-1:0] s_ad, s_md, s_amd;
    logic            obs_mem_ready, obs_amo_ready;

    // Reference model state.
    logic [4:0]      m_q_rd[$];
    logic [XLEN-1:0] m_q_data[$];
    logic            m_pend_v = 1'b0;
    logic [4:0]      m_pend_rd = '0;
    logic [XLEN-1:0] m_pend_d = '0;
    logic [31:0]     m_busy = '0;
    logic            m_we = 1'b0, m_awe = 1'b0;
    logic [4:0]      m_rd = '0, m_ard = '0;
    logic [XLEN-1:0] m_wd = '0, m_awd = '0;

    task automatic idle();
        s_rst = 1'b0; s_iv = 1'b0; s_av = 1'b0; s_mv = 1'b0; s_amv = 1'b0;
        s_ird = '0; s_ard = '0; s_mrd = '0; s_amrd = '0;
        s_ad = '0; s_md = '0; s_amd = '0;
    endtask

    task automatic model_update();
        int              sz;
        logic            main_v, c_v, hold, fire;
        logic [4:0]      main_rd, c_rd;
        logic [XLEN-1:0] main_d, c_d;
        if (s_rst) begin
            m_q_rd.delete(); m_q_data.delete();
            m_pend_v = 1'b0; m_busy = '0;
            m_we = 1'b0; m_rd = '0; m_wd = '0;
            m_awe = 1'b0; m_ard = '0; m_awd = '0;
        end else begin
            sz = m_q_rd.size();
            main_v = 1'b0; main_rd = '0; main_d = '0;
            if (s_av) begin
                main_v = 1'b1; main_rd = s_ard; main_d = s_ad;
            end else if (sz > 0) begin
                main_v = 1'b1; main_rd = m_q_rd.pop_front(); main_d = m_q_data.pop_front();
            end
            c_v = 1'b0; c_rd = '0; c_d = '0;
            if (m_pend_v) begin
                c_v = 1'b1; c_rd = m_pend_rd; c_d = m_pend_d;
            end else if (s_amv) begin
                c_v = 1'b1; c_rd = s_amrd; c_d = s_amd;
            end
            hold = c_v && main_v && (c_rd == main_rd) && (c_rd != 0);
            fire = c_v && !hold;
            m_pend_v = hold;
            if (hold) begin m_pend_rd = c_rd; m_pend_d = c_d; end
            if (main_v) m_busy[main_rd] = 1'b0;
            if (fire)   m_busy[c_rd] = 1'b0;
            if (s_iv)   m_busy[s_ird] = 1'b1;
            m_busy[0] = 1'b0;
            m_we = main_v && (main_rd != 0);
            if (main_v) begin m_rd = main_rd; m_wd = main_d; end
            m_awe = fire && (c_rd != 0);
            if (fire) begin m_ard = c_rd; m_awd = c_d; end
            if (s_mv && sz < DEPTH) begin
                m_q_rd.push_back(s_mrd); m_q_data.push_back(s_md);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        reset = s_rst;
        issue_valid = s_iv; issue_rd = s_ird;
        alu_valid = s_av;   alu_rd = s_ard;   alu_data = s_ad;
        mem_valid = s_mv;   mem_rd = s_mrd;   mem_data = s_md;
        amo_valid = s_amv;  amo_rd = s_amrd;  amo_data = s_amd;
        #1;
        obs_mem_ready = mem_ready;
        obs_amo_ready = amo_ready;
        if (!s_rst) begin
            check_eq("mem_ready", mem_ready, (m_q_rd.size() < DEPTH));
            check_eq("amo_ready", amo_ready, !m_pend_v);
        end
        model_update();
        @(posedge clk);
        #1;
        check_eq("write_enable", write_enable, m_we);
        check_eq("rd", rd, m_rd);
        check_eq("write_data", write_data, m_wd);
        check_eq("atomic_we", atomic_write_enable, m_awe);
        check_eq("atomic_rd", atomic_rd, m_ard);
        check_eq("atomic_data", atomic_write_data, m_awd);
        check_eq("busy", busy, m_busy);
        if (write_enable && atomic_write_enable && rd == atomic_rd && rd != 0)
            check_eq("dual_port_same_rd", 1'b1, 1'b0);
    endtask

    initial begin
        idle();
        s_rst = 1'b1;
        step();
        step();
        check_eq("rst_we", write_enable, 1'b0);
        check_eq("rst_awe", atomic_write_enable, 1'b0);
        check_eq("rst_busy", busy, 32'h0);
        check_eq("rst_rd", rd, 5'd0);
        check_eq("rst_wdata", write_data, 32'h0);

        // Single ALU write: appears next cycle, lasts one cycle.
        idle(); s_av = 1'b1; s_ard = 5'd5; s_ad = 32'h11;
        step();
        check_eq("alu_we", write_enable, 1'b1);
        check_eq("alu_rd", rd, 5'd5);
        check_eq("alu_data", write_data, 32'h11);
        idle(); step();
        check_eq("alu_we_off", write_enable, 1'b0);

        // ALU hogs the port while loads queue up.
        idle(); s_av = 1'b1; s_ard = 5'd20; s_ad = 32'h20; s_mv = 1'b1;
        s_mrd = 5'd6; s_md = 32'h60; step();
        s_mrd = 5'd7; s_md = 32'h70; step();
        s_mrd = 5'd8; s_md = 32'h80; step();
        check_eq("ld_full_ready", obs_mem_ready, 1'b0);
        step();
        s_av = 1'b0; step();
        check_eq("ld_first_rd", rd, 5'd6);
        check_eq("ld_first_we", write_enable, 1'b1);
        step();
        check_eq("ld_refill_ready", obs_mem_ready, 1'b1);
        check_eq("ld_second_rd", rd, 5'd7);
        s_mv = 1'b0; step();
        check_eq("ld_third_rd", rd, 5'd8);
        check_eq("ld_third_data", write_data, 32'h80);
        idle(); step();

        // AMO collides with a same-register load at the FIFO head.
        idle(); s_av = 1'b1; s_ard = 5'd21; s_ad = 32'h1; s_mv = 1'b1; s_mrd = 5'd9; s_md = 32'hB;
        step();
        idle(); s_amv = 1'b1; s_amrd = 5'd9; s_amd = 32'hA;
        step();
        check_eq("amo_main_rd", rd, 5'd9);
        check_eq("amo_main_data", write_data, 32'hB);
        check_eq("amo_delayed", atomic_write_enable, 1'b0);
        idle(); step();
        check_eq("amo_ready_hold", obs_amo_ready, 1'b0);
        check_eq("amo_we", atomic_write_enable, 1'b1);
        check_eq("amo_rd", atomic_rd, 5'd9);
        check_eq("amo_data", atomic_write_data, 32'hA);

        // Scoreboard set/clear priority.
        idle(); s_iv = 1'b1; s_ird = 5'd3; step();
        check_eq("busy3_set", busy[3], 1'b1);
        idle(); s_av = 1'b1; s_ard = 5'd3; s_ad = 32'h33; s_iv = 1'b1; s_ird = 5'd3; step();
        check_eq("busy3_set_wins", busy[3], 1'b1);
        idle(); s_iv = 1'b1; s_ird = 5'd0; step();
        check_eq("busy0_zero", busy[0], 1'b0);
        idle(); s_av = 1'b1; s_ard = 5'd3; s_ad = 32'h34; step();
        check_eq("busy3_clear", busy[3], 1'b0);

        // Reset with full FIFO and pending AMO.
        idle(); s_av = 1'b1; s_ard = 5'd22; s_mv = 1'b1; s_mrd = 5'd12; s_iv = 1'b1; s_ird = 5'd14;
        step();
        s_mrd = 5'd13; s_amv = 1'b1; s_amrd = 5'd22; s_amd = 32'h5; step();
        s_rst = 1'b1; step();
        check_eq("rst_mid_we", write_enable, 1'b0);
        check_eq("rst_mid_awe", atomic_write_enable, 1'b0);
        check_eq("rst_mid_busy", busy, 32'h0);
        idle(); step();
        check_eq("rst_mid_mem_ready", obs_mem_ready, 1'b1);
        check_eq("rst_mid_amo_ready", obs_amo_ready, 1'b1);
        check_eq("rst_mid_we_after", write_enable, 1'b0);

        // Load to x0 is consumed silently.
        idle(); s_mv = 1'b1; s_mrd = 5'd0; s_md = 32'hFF; step();
        check_eq("x0_accepted", obs_mem_ready, 1'b1);
        idle(); step();
        check_eq("x0_no_we", write_enable, 1'b0);
        check_eq("x0_fifo_count", dut.u_fifo.count, 2'd0);

        for (int i = 0; i < 1500; i++) begin
            s_rst  = ($urandom_range(0, 99) == 0);
            s_iv   = $urandom_range(0, 1) == 1;
            s_ird  = 5'($urandom_range(0, 7));
            s_av   = $urandom_range(0, 9) < 4;
            s_ard  = 5'($urandom_range(0, 7));
            s_ad   = $urandom;
            s_mv   = $urandom_range(0, 1) == 1;
            s_mrd  = 5'($urandom_range(0, 7));
            s_md   = $urandom;
            s_amv  = $urandom_range(0, 9) < 3;
            s_amrd = 5'($urandom_range(0, 7));
            s_amd  = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
